// File: rtl/seu_scan_sequencer.sv
// SEU scan sequencer: writes a known pattern to a register bank, dwells, then reads back and counts mismatches.
// Optional macro SEU_SEQ_REWRITE_EN adds a scrub write after every mismatching register check.
module seu_scan_sequencer #(
  parameter int DATA_WIDTH = 11,
  parameter int NUM_REGS   = 8,
  parameter int DWELL_W    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [DATA_WIDTH-1:0]            pattern,
  input  logic [DWELL_W-1:0]               dwell_cycles,
  output logic [NUM_REGS-1:0]              reg_wren,
  output logic [DATA_WIDTH-1:0]            reg_wdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   reg_rdata,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(NUM_REGS+1)-1:0]    err_regs,
  output logic [15:0]                      err_bits,
  output logic [$clog2(NUM_REGS)-1:0]      first_err_idx
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS+1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] DWELL = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
`ifdef SEU_SEQ_REWRITE_EN
  localparam logic [2:0] REWR  = 3'd5;
`endif

  logic [2:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [DWELL_W-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]         err_regs_q, err_regs_d;
  logic [15:0]           err_bits_q, err_bits_d;
  logic [IW-1:0]         first_q, first_d;
  logic                  busy_q, done_q;

  logic [DATA_WIDTH-1:0] exp_val;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] diff;
  logic [16:0]           bits_sum;
  logic                  last_idx;
  logic                  wr_state;

  // Odd registers hold the inverted pattern so adjacent cells store opposite values.
  assign exp_val  = idx_q[0] ? ~pat_q : pat_q;
  assign rd_val   = reg_rdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign diff     = rd_val ^ exp_val;
  assign bits_sum = {1'b0, err_bits_q} + 17'($countones(diff));
  assign last_idx = (idx_q == IW'(NUM_REGS-1));

`ifdef SEU_SEQ_REWRITE_EN
  assign wr_state = (state_q == WRITE) || (state_q == REWR);
`else
  assign wr_state = (state_q == WRITE);
`endif

  always_comb begin
    reg_wren  = '0;
    reg_wdata = '0;
    if (wr_state && !abort) begin
      reg_wren[idx_q] = 1'b1;
      reg_wdata       = exp_val;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    err_regs_d = err_regs_q;
    err_bits_d = err_bits_q;
    first_d    = first_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = WRITE;
          pat_d      = pattern;
          dwell_d    = dwell_cycles;
          idx_d      = '0;
          err_regs_d = '0;
          err_bits_d = '0;
          first_d    = '0;
        end
      end
      WRITE: begin
        idx_d = idx_q + IW'(1);
        if (last_idx) begin
          idx_d   = '0;
          cnt_d   = dwell_q;
          state_d = (dwell_q == '0) ? CHECK : DWELL;
        end
      end
      DWELL: begin
        if (cnt_q <= DWELL_W'(1)) state_d = CHECK;
        else                      cnt_d   = cnt_q - DWELL_W'(1);
      end
      CHECK: begin
        if (diff != '0) begin
          err_regs_d = err_regs_q + CW'(1);
          err_bits_d = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
          if (err_regs_q == '0) first_d = idx_q;
        end
`ifdef SEU_SEQ_REWRITE_EN
        if (diff != '0) begin
          state_d = REWR;
        end else if (last_idx) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`else
        if (last_idx) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
`endif
      end
`ifdef SEU_SEQ_REWRITE_EN
      REWR: begin
        if (last_idx) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          state_d = CHECK;
          idx_d   = idx_q + IW'(1);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pat_q      <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      err_regs_q <= '0;
      err_bits_q <= '0;
      first_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      err_regs_q <= err_regs_d;
      err_bits_q <= err_bits_d;
      first_q    <= first_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_regs      = err_regs_q;
  assign err_bits      = err_bits_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_seu_scan_sequencer.sv
// Scoreboard bench for seu_scan_sequencer: expected writes and run results are queued at start,
// a negedge monitor pops and compares them whenever reg_wren or done is presented.
module tb_seu_scan_sequencer;

  localparam int DW = 11;
  localparam int NR = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [DW-1:0]    pattern;
  logic [15:0]      dwell_cycles;
  logic [NR-1:0]    reg_wren;
  logic [DW-1:0]    reg_wdata;
  logic [NR*DW-1:0] reg_rdata;
  logic             busy;
  logic             done;
  logic [3:0]       err_regs;
  logic [15:0]      err_bits;
  logic [2:0]       first_err_idx;

  seu_scan_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(NR), .DWELL_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .dwell_cycles(dwell_cycles),
    .reg_wren(reg_wren), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .done(done), .err_regs(err_regs), .err_bits(err_bits),
    .first_err_idx(first_err_idx)
  );

  typedef struct {
    logic [NR-1:0] wren;
    logic [DW-1:0] wdata;
    int            cyc;
  } wr_t;

  typedef struct {
    int            cyc;
    logic [3:0]    regs;
    logic [15:0]   bits;
    logic [2:0]    first;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [NR*DW-1:0] bank_vec;
  logic [NR*DW-1:0] flip_vec;
  logic             inv_rd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal storage bank; flips and read inversion model upsets on the read path.
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++)
      if (reg_wren[i]) bank_vec[i*DW +: DW] <= reg_wdata;
  end
  assign reg_rdata = bank_vec ^ flip_vec ^ {(NR*DW){inv_rd}};

  always @(negedge clk) begin
    if (reset) begin
      if (reg_wren != '0) begin
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: wren=%02h wdata=%03h at cyc %0d, none expected", reg_wren, reg_wdata, cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (reg_wren !== w.wren || reg_wdata !== w.wdata || cyc != w.cyc) begin
            fails++;
            $display("FAIL write: got wren=%02h wdata=%03h cyc=%0d, expected wren=%02h wdata=%03h cyc=%0d",
                     reg_wren, reg_wdata, cyc, w.wren, w.wdata, w.cyc);
          end
        end
      end
      if (done) begin
        tests++;
        if (res_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: done=1 at cyc %0d, none expected", cyc);
        end else begin
          res_t r;
          r = res_q.pop_front();
          if (err_regs !== r.regs || err_bits !== r.bits || first_err_idx !== r.first || cyc != r.cyc) begin
            fails++;
            $display("FAIL result: got regs=%0d bits=%04h first=%0d cyc=%0d, expected regs=%0d bits=%04h first=%0d cyc=%0d",
                     err_regs, err_bits, first_err_idx, cyc, r.regs, r.bits, r.first, r.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] expv_of(input logic [DW-1:0] p, input int i);
    return (i % 2 == 1) ? ~p : p;
  endfunction

  // Issues start at a negedge; the following posedge is edge 0, cycle k is sampled at cyc == base+k.
  task automatic start_run(input logic [DW-1:0] p, input int d, input logic [NR-1:0] mism,
                           input logic [3:0] regs, input logic [15:0] bits, input logic [2:0] first,
                           input bit want_done);
    int   base;
    int   c;
    wr_t  w;
    res_t r;
    @(negedge clk);
    base = cyc;
    for (int i = 0; i < NR; i++) begin
      w.wren = NR'(1) << i; w.wdata = expv_of(p, i); w.cyc = base + i + 1;
      wr_q.push_back(w);
    end
    c = base + NR + d + 1;
    for (int i = 0; i < NR; i++) begin
      c++;
`ifdef SEU_SEQ_REWRITE_EN
      if (mism[i]) begin
        w.wren = NR'(1) << i; w.wdata = expv_of(p, i); w.cyc = c;
        wr_q.push_back(w);
        c++;
      end
`else
      if (mism[i] && c < 0) c = 0;
`endif
    end
    r.cyc = c; r.regs = regs; r.bits = bits; r.first = first;
    if (want_done) res_q.push_back(r);
    pattern      = p;
    dwell_cycles = 16'(d);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || res_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (wr_q.size() != 0 || res_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d writes and %0d results still pending, expected 0", name, wr_q.size(), res_q.size());
      wr_q.delete();
      res_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; dwell_cycles = '0;
    flip_vec = '0; inv_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wren", 32'(reg_wren), 0);
    chk("rst_wdata", 32'(reg_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err_regs", 32'(err_regs), 0);
    chk("rst_err_bits", 32'(err_bits), 0);
    chk("rst_first", 32'(first_err_idx), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run: done at cycle 21.
    start_run(11'h555, 4, 8'h00, 4'd0, 16'd0, 3'd0, 1'b1);
    chk("busy_running", 32'(busy), 1);
    wait_idle("clean");

    // Flips in regs 3 (2 bits) and 6 (1 bit) during DWELL.
    start_run(11'h555, 4, 8'h48, 4'd2, 16'd3, 3'd3, 1'b1);
    repeat (NR + 1) @(negedge clk);
    flip_vec[3*DW +: DW] = 11'h003;
    flip_vec[6*DW +: DW] = 11'h400;
    wait_idle("inject");
    flip_vec = '0;

    // Zero dwell: done at cycle 17.
    start_run(11'h0F0, 0, 8'h00, 4'd0, 16'd0, 3'd0, 1'b1);
    wait_idle("zero_dwell");

    // Abort in the 3rd DWELL cycle (cycle 11).
    start_run(11'h1A5, 6, 8'h00, 4'd0, 16'd0, 3'd0, 1'b0);
    repeat (NR + 2) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wren", 32'(reg_wren), 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done_busy", 32'(busy), 0);
    start_run(11'h1A5, 3, 8'h00, 4'd0, 16'd0, 3'd0, 1'b1);
    wait_idle("after_abort");

    // Start and abort together in IDLE: not started.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);

    // Start pulse during CHECK with another pattern is ignored.
    start_run(11'h123, 2, 8'h00, 4'd0, 16'd0, 3'd0, 1'b1);
    repeat (NR + 4) @(negedge clk);
    pattern = 11'h7FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("start_busy");

    // Every read inverted: 8 regs x 11 bits = 88 per run.
    inv_rd = 1'b1;
    start_run(11'h3C3, 1, 8'hFF, 4'd8, 16'd88, 3'd0, 1'b1);
    wait_idle("sat_run1");
    start_run(11'h3C3, 1, 8'hFF, 4'd8, 16'd88, 3'd0, 1'b1);
    wait_idle("sat_run2");

    // Preload near saturation while dwelling; the total must clamp.
    start_run(11'h3C3, 4, 8'hFF, 4'd8, 16'hFFFF, 3'd0, 1'b1);
    repeat (NR + 1) @(negedge clk);
    force dut.err_bits_q = 16'hFFF0;
    @(negedge clk);
    release dut.err_bits_q;
    wait_idle("sat_clamp");
    chk("sat_hold", 32'(err_bits), 32'hFFFF);
    inv_rd = 1'b0;

    // Reset mid-run forces reset values immediately.
    start_run(11'h0AA, 4, 8'h00, 4'd0, 16'd0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wren", 32'(reg_wren), 0);
    chk("midrst_err_bits", 32'(err_bits), 0);
    wr_q.delete();
    res_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    start_run(11'h555, 2, 8'h00, 4'd0, 16'd0, 3'd0, 1'b1);
    wait_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seu_scan_sequencer.md
# seu_scan_sequencer

Sequencer for an SEU flip-flop experiment over a bank of Hamming-protected registers. On a host start it writes a known pattern into every register one per cycle, dwells for a programmable exposure time, then reads each register back. It compares each read against the expected value and reports mismatching registers and bit counts. It sits between the experiment host interface and an external array of Hamming register cores, driving their write enables and shared write data.

## Interface
- DATA_WIDTH, 11, data bits per register (matches a 4-parity-bit core)
- NUM_REGS, 8, number of registers in the bank (>=2)
- DWELL_W, 16, width of the dwell counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  single-cycle run request, honoured only in IDLE
- abort  in  1  return to IDLE next cycle, no done pulse
- pattern  in  DATA_WIDTH  base pattern, captured at start
- dwell_cycles  in  DWELL_W  exposure length in cycles, captured at start
- reg_wren  out  NUM_REGS  one-hot write enable to the register bank
- reg_wdata  out  DATA_WIDTH  shared write data to all registers
- reg_rdata  in  NUM_REGS*DATA_WIDTH  flattened corrected read data, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes
- err_regs  out  $clog2(NUM_REGS+1)  count of mismatching registers in the last run
- err_bits  out  16  total mismatching bits in the last run, saturating at 16'hFFFF
- first_err_idx  out  $clog2(NUM_REGS)  lowest mismatching register index, valid when err_regs!=0

## Operation
- States: IDLE, WRITE, DWELL, CHECK, DONE.
- Expected value for register i: pattern if i is even, ~pattern if i is odd.
- IDLE: a start edge captures pattern and dwell_cycles, clears err_regs, err_bits and first_err_idx, sets idx=0, and moves to WRITE.
- WRITE: reg_wren=1<<idx and reg_wdata=expected(idx); idx increments each cycle. After idx=NUM_REGS-1, go to DWELL, or straight to CHECK if dwell_cycles==0.
- DWELL: down-counter loaded with dwell_cycles; reg_wren=0. Exit to CHECK when the counter reaches 1 in that cycle, giving exactly dwell_cycles cycles.
- CHECK: compare reg_rdata slice idx against expected(idx) in the same cycle.
  - Mismatch: err_regs+1; err_bits += popcount(XOR), saturating; first_err_idx set if this is the first mismatch.
  - After idx=NUM_REGS-1, go to DONE.
- DONE: done=1 for one cycle, then IDLE. Result outputs hold until the next start.
- abort in any non-IDLE state: next state IDLE, reg_wren=0, no done. Results keep their partial values.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, run not started.
- reg_wdata is 0 whenever reg_wren is 0.

## Timing
- Reset values: reg_wren=0, reg_wdata=0, busy=0, done=0, err_regs=0, err_bits=0, first_err_idx=0, state IDLE.
- All outputs are registered except reg_wren and reg_wdata, which decode from registered state and idx.
- With start sampled at edge 0 and no mismatches (REWRITE off):
  - WRITE occupies cycles 1..NUM_REGS.
  - DWELL takes the next dwell_cycles cycles.
  - CHECK takes NUM_REGS cycles.
  - done is high in cycle 2*NUM_REGS+dwell_cycles+1.
- Result counters update at the edge ending each CHECK cycle. They are final when done is high.
- Reset asserted mid-run forces IDLE and reset values immediately.

## Configuration
- SEU_SEQ_REWRITE_EN defined: when a CHECK cycle finds a mismatch, the next cycle is a rewrite cycle.
  - In the rewrite cycle, reg_wren=1<<idx and reg_wdata=expected(idx); idx does not advance.
  - CHECK then resumes at idx+1.
  - Each mismatching register adds one cycle to run length.
- Undefined: no rewrite; the register bank is never written outside WRITE.

## Test plan
- Clean run: NUM_REGS=8, pattern=11'h555, dwell=4, bank models ideal storage.
  - reg_wren walks 01..80 with wdata 555/2AA alternating.
  - done at cycle 21; err_regs=0, err_bits=0.
- Injected flips: during DWELL, force register 3 to expected^11'h003 and register 6 to expected^11'h400.
  - err_regs=2, err_bits=3, first_err_idx=3.
  - With SEU_SEQ_REWRITE_EN: two extra write pulses (08 then 40), done at cycle 23.
- Zero dwell: dwell=0 → CHECK directly after WRITE; done at cycle 17.
- Abort: assert abort in the 3rd DWELL cycle.
  - busy=0 next cycle, no done pulse, reg_wren stays 0.
  - A following start runs normally.
- Start while busy: pulse start during CHECK with a different pattern → ignored; results reflect the original pattern.
- Saturation: DATA_WIDTH=11, NUM_REGS=8, every register read as ~expected over repeated start/done runs.
  - err_bits=88 per run; never exceeds 16'hFFFF.
  - Separately force err_bits preload near saturation (bench-driven preload) → clamps at FFFF.
